// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_scoreboard
//  Purpose  : Per-register latency countdown that stalls ID on pending sources
//  Revision : 1.0
// ============================================================================
module hazard_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int REG_AW   = 5,
   parameter int NUM_SRC  = 2,
   parameter int CNT_W    = 2,
   parameter int MAX_LAT  = 3,
   parameter int STAT_W   = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      issue_valid,
   input  logic                      issue_we,
   input  logic [REG_AW-1:0]         issue_wreg,
   input  logic [CNT_W-1:0]          issue_lat,
   input  logic [NUM_SRC-1:0]        src_valid,
   input  logic [NUM_SRC*REG_AW-1:0] src_reg,
   input  logic                      flush,
   output logic                      stall,
   output logic                      pc_if_id_write,
   output logic                      bubble,
   output logic                      issue_ack,
   output logic [NUM_REGS-1:0]       busy_mask,
   output logic [STAT_W-1:0]         stall_cycles
);

   localparam logic [CNT_W-1:0] C_MAX_LAT = CNT_W'(MAX_LAT);

   logic [CNT_W-1:0]   w_cnt [NUM_REGS];
   logic [NUM_SRC-1:0] w_hit;
   logic [CNT_W-1:0]   w_lat_c;
   logic [STAT_W-1:0]  r_stat;

   assign w_lat_c = (issue_lat > C_MAX_LAT) ? C_MAX_LAT : issue_lat;

   // Register 0 is hardwired zero: never busy, never written.
   assign w_cnt[0]     = '0;
   assign busy_mask[0] = 1'b0;

   generate
      for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
         logic [CNT_W-1:0] r_cnt;
         logic [CNT_W-1:0] w_dec;
         logic             w_set;

         assign w_dec = (r_cnt != '0) ? r_cnt - CNT_W'(1) : '0;
         assign w_set = issue_ack & issue_we & (issue_wreg == REG_AW'(r))
                        & (w_lat_c != '0);

         // Taking the max keeps an older, slower producer from being shortened.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               r_cnt <= '0;
            else if (w_set)
               r_cnt <= (w_lat_c > w_dec) ? w_lat_c : w_dec;
            else
               r_cnt <= w_dec;
         end

         assign w_cnt[r]     = r_cnt;
         assign busy_mask[r] = (r_cnt != '0);
      end
   endgenerate

   generate
      for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
         logic [REG_AW-1:0] w_sreg;
         logic              w_busy;

         assign w_sreg = src_reg[i*REG_AW +: REG_AW];

         // Decoded lookup avoids indexing past NUM_REGS for wide addresses.
         always_comb begin
            w_busy = 1'b0;
            for (int r = 0; r < NUM_REGS; r++) begin
               if (w_sreg == REG_AW'(r))
                  w_busy = busy_mask[r];
            end
         end

         assign w_hit[i] = src_valid[i] & w_busy;
      end
   endgenerate

   assign stall          = |w_hit;
   assign pc_if_id_write = ~stall;
   assign bubble         = stall | flush;
   assign issue_ack      = issue_valid & ~stall & ~flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_stat <= '0;
      else if (stall && (r_stat != '1))
         r_stat <= r_stat + STAT_W'(1);
   end

   assign stall_cycles = r_stat;

endmodule
`default_nettype wire
